// File: rtl/ddr_read_arbiter.sv
// Round-robin arbiter sharing one DDR read path (address FIFO + read-data FIFO)
// among three burst-read clients; one burst outstanding, beats routed to the owner.
module ddr_read_arbiter #(
  parameter int unsigned BURST_BEATS = 2,
  parameter int unsigned TIMEOUT     = 255,
  parameter logic [2:0]  RD_CMD      = 3'b001
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [2:0]   req_valid,
  input  logic [30:0]  req_addr0,
  input  logic [30:0]  req_addr1,
  input  logic [30:0]  req_addr2,
  output logic [2:0]   req_ack,
  output logic [2:0]   rd_valid,
  output logic [127:0] rd_data,
  output logic         rd_last,
  output logic         af_wr_en,
  output logic [2:0]   af_cmd_din,
  output logic [30:0]  af_addr_din,
  input  logic         af_full,
  input  logic         rdf_valid,
  input  logic [127:0] rdf_dout,
  output logic         rdf_rd_en,
  output logic         busy,
  output logic         err
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RETURN} state_t;

  localparam logic [1:0] LAST_CNT  = 2'(BURST_BEATS - 1);
  localparam logic [7:0] TIMER_MAX = 8'(TIMEOUT - 1);

  state_t         state_q, state_d;
  logic [1:0]     last_grant_q, last_grant_d;
  logic [1:0]     owner_q, owner_d;
  logic [30:0]    addr_q, addr_d;
  logic [1:0]     beat_cnt_q, beat_cnt_d;
  logic [7:0]     timer_q, timer_d;
  logic           err_q, err_d;
  logic [2:0]     rd_valid_q, rd_valid_d;
  logic           rd_last_q, rd_last_d;
  logic [127:0]   rd_data_q, rd_data_d;

  function automatic logic [1:0] rr_pick(input logic [2:0] req, input logic [1:0] last);
    logic [1:0] pick;
    logic [1:0] idx;
    logic       found;
    pick  = 2'd0;
    found = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      idx = 2'((int'(last) + k) % 3);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    addr_d       = addr_q;
    beat_cnt_d   = beat_cnt_q;
    timer_d      = timer_q;
    err_d        = err_q;
    rd_valid_d   = '0;
    rd_last_d    = 1'b0;
    rd_data_d    = rd_data_q;
    req_ack      = '0;
    af_wr_en     = 1'b0;
    af_addr_din  = '0;
    rdf_rd_en    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rdf_valid) begin
          rdf_rd_en = 1'b1;
          err_d     = 1'b1;
        end
        if (|req_valid) begin
          owner_d = rr_pick(req_valid, last_grant_q);
          case (owner_d)
            2'd0:    addr_d = req_addr0;
            2'd1:    addr_d = req_addr1;
            default: addr_d = req_addr2;
          endcase
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (rdf_valid) begin
          rdf_rd_en = 1'b1;
          err_d     = 1'b1;
        end
        af_wr_en    = 1'b1;
        af_addr_din = addr_q;
        if (!af_full) begin
          req_ack      = 3'b001 << owner_q;
          last_grant_d = owner_q;
          timer_d      = '0;
          beat_cnt_d   = '0;
          state_d      = S_WAIT;
        end
      end
      S_WAIT: begin
        rdf_rd_en = rdf_valid;
        if (rdf_valid) begin
          rd_valid_d = 3'b001 << owner_q;
          rd_data_d  = rdf_dout;
          rd_last_d  = (beat_cnt_q == LAST_CNT);
          beat_cnt_d = beat_cnt_q + 2'd1;
          timer_d    = '0;
          if (beat_cnt_q == LAST_CNT) state_d = S_RETURN;
        end else if (timer_q == TIMER_MAX) begin
          // Abandon the burst; anything arriving later is treated as stray.
          err_d   = 1'b1;
          timer_d = '0;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (rst) begin
      req_ack     = '0;
      af_wr_en    = 1'b0;
      af_addr_din = '0;
      rdf_rd_en   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= 2'd2;
      owner_q      <= 2'd0;
      addr_q       <= '0;
      beat_cnt_q   <= '0;
      timer_q      <= '0;
      err_q        <= 1'b0;
      rd_valid_q   <= '0;
      rd_last_q    <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      addr_q       <= addr_d;
      beat_cnt_q   <= beat_cnt_d;
      timer_q      <= timer_d;
      err_q        <= err_d;
      rd_valid_q   <= rd_valid_d;
      rd_last_q    <= rd_last_d;
      rd_data_q    <= rd_data_d;
    end
  end

  assign af_cmd_din = RD_CMD;
  assign rd_valid   = rd_valid_q;
  assign rd_last    = rd_last_q;
  assign rd_data    = rd_data_q;
  assign err        = err_q;
  assign busy       = (state_q != S_IDLE) && !rst;

endmodule

// File: tb/tb_ddr_read_arbiter.sv
// Randomized bench for ddr_read_arbiter against a transaction-level model
// (round-robin pick from the last acked client, per-burst beat expectations).
module tb_ddr_read_arbiter;

  localparam int BB = 2;
  localparam int TO = 255;

  logic         clk;
  logic         rst;
  logic [2:0]   req_valid;
  logic [30:0]  req_addr0, req_addr1, req_addr2;
  logic [2:0]   req_ack;
  logic [2:0]   rd_valid;
  logic [127:0] rd_data;
  logic         rd_last;
  logic         af_wr_en;
  logic [2:0]   af_cmd_din;
  logic [30:0]  af_addr_din;
  logic         af_full;
  logic         rdf_valid;
  logic [127:0] rdf_dout;
  logic         rdf_rd_en;
  logic         busy;
  logic         err;

  ddr_read_arbiter #(.BURST_BEATS(BB), .TIMEOUT(TO), .RD_CMD(3'b001)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr0(req_addr0), .req_addr1(req_addr1), .req_addr2(req_addr2),
    .req_ack(req_ack), .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
    .af_wr_en(af_wr_en), .af_cmd_din(af_cmd_din), .af_addr_din(af_addr_din), .af_full(af_full),
    .rdf_valid(rdf_valid), .rdf_dout(rdf_dout), .rdf_rd_en(rdf_rd_en),
    .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // reference model state
  int          lg_m;
  logic        err_m;
  logic [30:0] addr_m [3];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int rr_model(input logic [2:0] mask);
    for (int k = 1; k <= 3; k++)
      if (mask[(lg_m + k) % 3]) return (lg_m + k) % 3;
    return -1;
  endfunction

  task automatic set_addrs(input logic [30:0] a0, input logic [30:0] a1, input logic [30:0] a2);
    addr_m[0] = a0; addr_m[1] = a1; addr_m[2] = a2;
    req_addr0 = a0; req_addr1 = a1; req_addr2 = a2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0; af_full = 1'b0; rdf_valid = 1'b0; rdf_dout = '0;
    tick();
    tick();
    rst = 1'b0;
    lg_m  = 2;
    err_m = 1'b0;
    #1;
  endtask

  // One complete burst; beat data given explicitly (d0,d1) or random when rnd=1.
  task automatic do_burst(input logic [2:0] mask, input int full_n, input int g0, input int g1,
                          input logic rnd, input logic [127:0] d0, input logic [127:0] d1,
                          output int winner);
    int          w;
    int          g;
    logic [2:0]  oh;
    logic [127:0] beat;
    w  = rr_model(mask);
    winner = w;
    oh = 3'b001 << w;
    req_valid = mask;
    tick();
    for (int c = 0; c <= full_n; c++) begin
      af_full = (c < full_n);
      #1;
      chk("af_wr_en", af_wr_en, 1'b1);
      chk("af_addr", af_addr_din, addr_m[w]);
      chk("af_cmd", af_cmd_din, 3'b001);
      chk("req_ack", req_ack, (c < full_n) ? 3'b000 : oh);
      tick();
    end
    af_full   = 1'b0;
    lg_m      = w;
    req_valid = mask & ~oh;
    for (int b = 0; b < BB; b++) begin
      g = (b == 0) ? g0 : g1;
      for (int k = 0; k < g; k++) begin
        rdf_valid = 1'b0;
        #1;
        chk("rd_en_gap", rdf_rd_en, 1'b0);
        if (!(k == 0 && b > 0)) chk("rd_valid_gap", rd_valid, 3'b000);
        tick();
      end
      beat = rnd ? {$urandom, $urandom, $urandom, $urandom} : ((b == 0) ? d0 : d1);
      rdf_valid = 1'b1;
      rdf_dout  = beat;
      #1;
      chk("rd_en_beat", rdf_rd_en, 1'b1);
      chk("ack_in_wait", req_ack, 3'b000);
      tick();
      rdf_valid = 1'b0;
      chk("rd_valid", rd_valid, oh);
      chk("rd_data", rd_data, beat);
      chk("rd_last", rd_last, (b == BB - 1));
    end
    chk("busy_return", busy, 1'b1);
    tick();
    req_valid = '0;
    chk("busy_idle", busy, 1'b0);
    chk("rd_valid_idle", rd_valid, 3'b000);
    chk("err", err, err_m);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int n;
    logic [2:0] m;
    set_addrs(31'h0, 31'h0, 31'h0);
    rst = 1'b1;
    req_valid = '0; af_full = 1'b0; rdf_valid = 1'b0; rdf_dout = '0;
    tick();
    tick();
    // during reset
    chk("rst_busy", busy, 1'b0);
    chk("rst_ack", req_ack, 3'b000);
    chk("rst_wr_en", af_wr_en, 1'b0);
    chk("rst_cmd", af_cmd_din, 3'b001);
    chk("rst_err", err, 1'b0);
    rst = 1'b0;
    lg_m = 2; err_m = 1'b0;
    #1;
    chk("post_rst_rd_valid", rd_valid, 3'b000);
    chk("post_rst_rd_last", rd_last, 1'b0);
    chk("post_rst_rd_data", rd_data, 128'h0);
    chk("post_rst_addr", af_addr_din, 31'h0);
    chk("post_rst_rd_en", rdf_rd_en, 1'b0);

    // single request, no backpressure
    set_addrs(31'h0000100, 31'h0000200, 31'h0000300);
    do_burst(3'b001, 0, 0, 0, 1'b0, {32{4'hA}}, {32{4'hB}}, w);
    chk("single_winner", w, 0);

    // round-robin from reset
    do_reset();
    for (int i = 0; i < 4; i++) begin
      do_burst(3'b111, 0, 0, 0, 1'b1, '0, '0, w);
      chk("rr_order", w, i % 3);
    end

    // af_full backpressure on client 2
    set_addrs(31'h0000100, 31'h0000200, 31'h7FFFFF0);
    do_burst(3'b100, 5, 0, 0, 1'b1, '0, '0, w);
    chk("bp_winner", w, 2);

    // beat gap of 3 cycles between beats
    do_burst(3'b010, 0, 0, 3, 1'b1, '0, '0, w);

    // randomized bursts
    for (int i = 0; i < 30; i++) begin
      set_addrs(31'($urandom), 31'($urandom), 31'($urandom));
      m = 3'($urandom_range(1, 7));
      do_burst(m, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), 1'b1, '0, '0, w);
    end

    // stray beat while idle
    rdf_valid = 1'b1;
    rdf_dout  = {4{32'hDEADBEEF}};
    #1;
    chk("stray_rd_en", rdf_rd_en, 1'b1);
    tick();
    rdf_valid = 1'b0;
    err_m = 1'b1;
    chk("stray_rd_valid", rd_valid, 3'b000);
    chk("stray_err", err, 1'b1);
    tick();
    chk("stray_err_sticky", err, 1'b1);
    chk("stray_busy", busy, 1'b0);

    // timeout in WAIT, then a normal burst
    do_reset();
    req_valid = 3'b001;
    tick();
    af_full = 1'b0;
    tick();
    req_valid = '0;
    lg_m = 0;
    n = 0;
    while (busy && n < 400) begin
      tick();
      n++;
    end
    chk("timeout_cycles", n, TO);
    chk("timeout_err", err, 1'b1);
    chk("timeout_rd_valid", rd_valid, 3'b000);
    err_m = 1'b1;
    do_burst(3'b011, 0, 1, 0, 1'b1, '0, '0, w);
    chk("after_timeout_winner", w, 1);

    // reset in the middle of a burst
    do_reset();
    req_valid = 3'b001;
    tick();
    tick();
    req_valid = '0;
    rdf_valid = 1'b1;
    rdf_dout  = {4{32'h12345678}};
    tick();
    rdf_valid = 1'b0;
    chk("mid_beat1", rd_valid, 3'b001);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_rd_valid", rd_valid, 3'b000);
    chk("mid_rst_err", err, 1'b0);
    lg_m = 2; err_m = 1'b0;
    rdf_valid = 1'b1;
    #1;
    chk("late_rd_en", rdf_rd_en, 1'b1);
    tick();
    rdf_valid = 1'b0;
    err_m = 1'b1;
    chk("late_err", err, 1'b1);
    chk("late_rd_valid", rd_valid, 3'b000);
    do_burst(3'b010, 0, 0, 0, 1'b1, '0, '0, w);
    chk("after_late_winner", w, 1);
    do_burst(3'b111, 0, 0, 0, 1'b1, '0, '0, w);
    chk("after_late_rr", w, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
